// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for the pulse train generator:
// state encodings, length-field width, latched configuration record.
package pulse_gen_pkg;

  localparam int DIV_W_DEF = 8;
  localparam int LEN_W     = 4;
  localparam int ST_W      = 3;

  typedef logic [ST_W-1:0]  state_t;
  typedef logic [LEN_W-1:0] len_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_WAIT = 3'd1;
  localparam state_t ST_HIGH = 3'd2;
  localparam state_t ST_LOW  = 3'd3;
  localparam state_t ST_DONE = 3'd4;

  localparam len_t LEN_ZERO = 4'd0;
  localparam len_t LEN_ONE  = 4'd1;

  typedef struct packed {
    len_t n;
    len_t high;
    len_t low;
  } cfg_t;

  // A programmed length of zero still yields one tick of phase.
  function automatic len_t eff_len(input len_t raw);
    return (raw == LEN_ZERO) ? LEN_ONE : raw;
  endfunction

endpackage

// File: rtl/pulse_train_gen_if.sv
// Request/parameter inputs and pulse-train outputs of the generator,
// with master (requester) and slave (generator) views.
interface pulse_train_gen_if;

  logic                 start;
  pulse_gen_pkg::len_t  n_pulses;
  pulse_gen_pkg::len_t  high_len;
  pulse_gen_pkg::len_t  low_len;
  logic                 signal_out;
  logic                 busy;
  logic                 done;

  modport master (
    output start, n_pulses, high_len, low_len,
    input  signal_out, busy, done
  );

  modport slave (
    input  start, n_pulses, high_len, low_len,
    output signal_out, busy, done
  );

endinterface

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle clock enable every
// 2^DIV_W cycles of clk; no derived clock is created.
module tick_gen
  import pulse_gen_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  // Next divider value: plain wrap-around increment.
  always_comb begin
    div_d = div_q + DIV_W'(1);
  end

  // Divider register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign tick = (div_q == {DIV_W{1'b1}});

endmodule

// File: rtl/pulse_train_gen.sv
// Tick-paced pulse train generator: emits n high pulses of high_len ticks
// separated by low_len-tick gaps, then a one-cycle done pulse.
module pulse_train_gen
  import pulse_gen_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input logic              clk,
  input logic              rst,
  pulse_train_gen_if.slave bus
);

  logic   tick;
  state_t state_q, state_d;
  cfg_t   cfg_q, cfg_d;
  len_t   count_q, count_d;
  len_t   left_q, left_d;
  logic   sig_q, sig_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;

  tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Next-state and datapath; outputs are derived from the next state so they register in step.
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    count_d = count_q;
    left_d  = left_q;
    sig_d   = sig_q;
    case (state_q)
      ST_IDLE: begin
        sig_d = 1'b0;
        if (bus.start) begin
          cfg_d.n    = bus.n_pulses;
          cfg_d.high = bus.high_len;
          cfg_d.low  = bus.low_len;
          state_d    = (bus.n_pulses != LEN_ZERO) ? ST_WAIT : ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (tick) begin
          state_d = ST_HIGH;
          sig_d   = 1'b1;
          count_d = eff_len(cfg_q.high);
          left_d  = cfg_q.n;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HIGH: begin
        if (tick && (count_q > LEN_ONE)) begin
          count_d = count_q - LEN_ONE;
        end else if (tick && (left_q == LEN_ONE)) begin
          state_d = ST_DONE;
          sig_d   = 1'b0;
          count_d = LEN_ZERO;
          left_d  = LEN_ZERO;
        end else if (tick) begin
          state_d = ST_LOW;
          sig_d   = 1'b0;
          count_d = eff_len(cfg_q.low);
          left_d  = left_q - LEN_ONE;
        end else begin
          state_d = ST_HIGH;
        end
      end
      ST_LOW: begin
        if (tick && (count_q > LEN_ONE)) begin
          count_d = count_q - LEN_ONE;
        end else if (tick) begin
          state_d = ST_HIGH;
          sig_d   = 1'b1;
          count_d = eff_len(cfg_q.high);
        end else begin
          state_d = ST_LOW;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        sig_d   = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        sig_d   = 1'b0;
        count_d = LEN_ZERO;
        left_d  = LEN_ZERO;
      end
    endcase
    busy_d = (state_d == ST_WAIT) || (state_d == ST_HIGH) || (state_d == ST_LOW);
    done_d = (state_d == ST_DONE);
  end

  // State, counters, latched configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      count_q <= LEN_ZERO;
      left_q  <= LEN_ZERO;
      sig_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      count_q <= count_d;
      left_q  <= left_d;
      sig_q   <= sig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.signal_out = sig_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench for pulse_train_gen (DIV_W=2): expected output runs
// {signal_out,busy,done} with length and start cycle are queued per train.
module tb_pulse_train_gen;
  import pulse_gen_pkg::*;

  typedef struct {
    logic [2:0] tup;
    int         len;
    int         st;
  } run_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  run_t       exp_q[$];
  int         exp_st = 0;
  int         ca = 0;
  logic       mon_en = 1'b0;
  logic [2:0] prev_tup = 3'b000;
  int         cur_len = 0;
  int         cur_st = 0;

  pulse_train_gen_if bus();

  pulse_train_gen #(.DIV_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Mirrors the divider phase: cyc mod 4 equals the divider value after each edge.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] tup, input int len);
    run_t r;
    r.tup = tup;
    r.len = len;
    r.st  = exp_st;
    exp_q.push_back(r);
    exp_st += len;
  endtask

  task automatic close_run();
    run_t r;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL run: unexpected tup=%b len=%0d start=%0d", prev_tup, cur_len, cur_st);
    end else begin
      r = exp_q.pop_front();
      if (r.tup !== prev_tup || r.len != cur_len || r.st != cur_st) begin
        n_fail++;
        $display("FAIL run: got tup=%b len=%0d start=%0d, want tup=%b len=%0d start=%0d",
                 prev_tup, cur_len, cur_st, r.tup, r.len, r.st);
      end
    end
  endtask

  // Monitor: measure each non-idle output run and compare it when it ends.
  always @(negedge clk) begin : mon
    logic [2:0] tup;
    if (mon_en) begin
      tup = {bus.signal_out, bus.busy, bus.done};
      if (tup === prev_tup && tup !== 3'b000) begin
        cur_len++;
      end else begin
        if (prev_tup !== 3'b000) close_run();
        if (tup !== 3'b000) begin
          cur_st  = cyc;
          cur_len = 1;
        end
      end
      prev_tup = tup;
    end
  end

  // Raise start so it is accepted on the edge where the divider wraps 3 -> 0.
  task automatic start_train(input logic [3:0] n, input logic [3:0] h, input logic [3:0] l);
    int g;
    g = 0;
    @(negedge clk);
    while ((cyc % 4) != 3 && g < 8) begin
      @(negedge clk);
      g++;
    end
    bus.start    = 1'b1;
    bus.n_pulses = n;
    bus.high_len = h;
    bus.low_len  = l;
    ca     = cyc + 1;
    exp_st = ca;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    int g;
    g = 0;
    while (cyc != target && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("wait_cyc", cyc, target);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    repeat (4) @(negedge clk);
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start    = 1'b0;
    bus.n_pulses = 4'd0;
    bus.high_len = 4'd0;
    bus.low_len  = 4'd0;

    // Reset held for three edges, then idle with no start.
    repeat (3) @(negedge clk);
    check("rst_sig", bus.signal_out, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_busy", bus.busy, 1'b0);

    // n=2 high=3 low=2: wait 4, high 12, low 8, high 12, done 1.
    start_train(4'd2, 4'd3, 4'd2);
    push(3'b010, 4); push(3'b110, 12); push(3'b010, 8); push(3'b110, 12); push(3'b001, 1);
    drain();

    // n=0: done only, one clk after acceptance.
    start_train(4'd0, 4'd5, 4'd5);
    push(3'b001, 1);
    drain();

    // n=1 with zero lengths: single 4-clk pulse.
    start_train(4'd1, 4'd0, 4'd0);
    push(3'b010, 4); push(3'b110, 4); push(3'b001, 1);
    drain();

    // Re-start during HIGH and during DONE with different inputs is ignored.
    start_train(4'd2, 4'd1, 4'd1);
    push(3'b010, 4); push(3'b110, 4); push(3'b010, 4); push(3'b110, 4); push(3'b001, 1);
    wait_cyc(ca + 5);
    bus.start = 1'b1; bus.n_pulses = 4'd5; bus.high_len = 4'd7; bus.low_len = 4'd7;
    wait_cyc(ca + 7);
    bus.start = 1'b0;
    wait_cyc(ca + 15);
    bus.start = 1'b1;
    wait_cyc(ca + 17);
    bus.start = 1'b0;
    drain();

    // Reset in the middle of the first HIGH of an n=3 train.
    start_train(4'd3, 4'd2, 4'd1);
    push(3'b010, 4); push(3'b110, 5);
    wait_cyc(ca + 8);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_sig", bus.signal_out, 1'b0);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_done", bus.done, 1'b0);
    check("midrst_state", dut.state_q, ST_IDLE);
    rst = 1'b0;
    drain();

    // Fresh full train after the reset.
    start_train(4'd3, 4'd2, 4'd1);
    push(3'b010, 4); push(3'b110, 8); push(3'b010, 4); push(3'b110, 8);
    push(3'b010, 4); push(3'b110, 8); push(3'b001, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_train_gen.md
PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001 Parameter: DIV_W, default 8, tick-divider width; one tick SHALL occur every 2^DIV_W clk cycles.
REQ-002 clk  input  1  single system clock; all state SHALL update on posedge clk only.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request; SHALL be sampled on every clk edge, acted on only in IDLE.
REQ-005 n_pulses  input  4  number of high pulses to emit, 0..15.
REQ-006 high_len  input  4  high width in ticks; 0 SHALL be treated as 1.
REQ-007 low_len  input  4  low gap in ticks between pulses; 0 SHALL be treated as 1.
REQ-008 signal_out  output  1  generated pulse train, registered.
REQ-009 busy  output  1  high in WAIT, HIGH and LOW states.
REQ-010 done  output  1  one-clk completion pulse.

Function
REQ-011 Tick: free-running DIV_W-bit counter, increments every clk; tick SHALL be 1 when counter equals 2^DIV_W-1.
REQ-012 States: IDLE, WAIT, HIGH, LOW, DONE; the state register SHALL be the only source of control decisions.
REQ-013 IDLE and start=1: n_pulses, high_len and low_len SHALL be latched; n_pulses!=0 -> WAIT; n_pulses=0 -> DONE.
REQ-014 WAIT and tick: -> HIGH, signal_out<=1, phase count<=eff_high, pulses_left<=latched n.
REQ-015 HIGH and tick with count>1: count decrements, state holds.
REQ-016 HIGH and tick with count==1: pulses_left==1 -> DONE with signal_out<=0; otherwise -> LOW, signal_out<=0, count<=eff_low, pulses_left decrements.
REQ-017 LOW and tick with count==1: -> HIGH, signal_out<=1, count<=eff_high; LOW and tick with count>1: count decrements.
REQ-018 Each high phase SHALL last exactly eff_high*2^DIV_W clk cycles. Each gap SHALL last exactly eff_low*2^DIV_W clk cycles.
REQ-019 DONE: done=1 for exactly one clk cycle, then -> IDLE unconditionally.
REQ-020 start outside IDLE, including during DONE, SHALL be ignored without side effects; latched parameters SHALL NOT change mid-train.
REQ-021 Input changes after acceptance SHALL NOT affect the train in progress.
REQ-022 No state other than WAIT/HIGH/LOW SHALL drive busy=1; an unreachable state encoding SHALL return to IDLE with all outputs 0 on the next clk.

Reset
REQ-023 rst=1 at a clk edge SHALL force IDLE, signal_out=0, busy=0, done=0, divider=0, counters=0, regardless of state, including mid-HIGH.
REQ-024 rst SHALL take priority over start and tick in the same cycle.

Structure
REQ-025 State enum, DIV_W default, and length-field width (4) SHALL live in a shared package, pulse_gen_pkg.
REQ-026 Tick divider SHALL be one sub-module, tick_gen (clk, rst, tick); it SHALL be a clock-enable generator, not a derived clock.
REQ-027 All flops SHALL be on clk; no other clock domain.

Verification (DIV_W=2, tick every 4 clks)
REQ-028 rst held 3 cycles then released -> signal_out=0, busy=0, done=0; no activity without start.
REQ-029 start with n=2, high=3, low=2 -> signal_out high 12 clks, low 8, high 12; then done=1 for 1 clk, coincident with the final fall; busy=0 afterwards.
REQ-030 start with n=0 -> done=1 exactly one clk after acceptance; signal_out and busy never 1.
REQ-031 start with n=1, high=0, low=0 -> a single 4-clk high pulse, then done.
REQ-032 start re-asserted during HIGH and during DONE with different inputs -> ignored; the train matches the original parameters.
REQ-033 rst asserted mid-HIGH of an n=3 train -> next edge signal_out=0, busy=0, state IDLE; a fresh start then produces a correct full train.
